// File: rtl/key_matrix_scan_if.sv
// Keypad matrix signals plus the producer side of the display key bus.
// master = scanner (drives rows and key bus), slave = keypad/display side.
interface key_matrix_scan_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key;
   logic       key_valid;
   logic       pressed;

   modport master (
      input  col,
      output row,
      output key,
      output key_valid,
      output pressed
   );

   modport slave (
      output col,
      input  row,
      input  key,
      input  key_valid,
      input  pressed
   );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 active-low keypad scanner with debounce; emits one single-cycle key code per press.
// '#' (code F) is indistinguishable from the idle bus value, so its press is tracked but never emitted.
module key_matrix_scan #(
   parameter int unsigned ROW_TICKS      = 4,
   parameter int unsigned DEBOUNCE_TICKS = 20
) (
   input  logic              clk,
   input  logic              rst,
   key_matrix_scan_if.master bus
);
   localparam int SW = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cs1_q, cs1_d;
   logic [3:0]      cs_q, cs_d;
   logic [SW-1:0]   slot_q, slot_d;
   logic [1:0]      ridx_q, ridx_d;
   logic [1:0]      cidx_q, cidx_d;
   logic [3:0]      lcol_q, lcol_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic [3:0]      row_q, row_d;
   logic [3:0]      key_q, key_d;
   logic            key_valid_q, key_valid_d;
   logic            pressed_q, pressed_d;

   logic [3:0]      lo;
   logic            one_low;
   logic [1:0]      low_idx;
   logic [3:0]      emit_code;

   function automatic logic [3:0] code_at(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   // Exactly one column low is a clean single press; several low is a chord/ghost.
   always_comb begin
      lo      = ~cs_q;
      one_low = (lo != 4'b0000) && ((lo & (lo - 4'd1)) == 4'b0000);
      low_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (lo[i]) low_idx = 2'(i);
      end
   end

   assign emit_code = code_at(ridx_q, cidx_q);

   always_comb begin
      state_d     = state_q;
      cs1_d       = bus.col;
      cs_d        = cs1_q;
      slot_d      = slot_q;
      ridx_d      = ridx_q;
      cidx_d      = cidx_q;
      lcol_d      = lcol_q;
      dcnt_d      = dcnt_q;
      key_d       = 4'hF;
      key_valid_d = 1'b0;
      pressed_d   = pressed_q;

      case (state_q)
         SCAN: begin
            if (slot_q == SW'(ROW_TICKS - 1)) begin
               slot_d = '0;
               if (one_low) begin
                  state_d = DEBOUNCE;
                  lcol_d  = cs_q;
                  cidx_d  = low_idx;
                  dcnt_d  = '0;
               end else begin
                  ridx_d = ridx_q + 2'd1;
               end
            end else begin
               slot_d = slot_q + SW'(1);
            end
         end
         DEBOUNCE: begin
            if (cs_q == lcol_q) begin
               if (dcnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
                  // Outputs are loaded on entry so they are visible during the EMIT cycle.
                  state_d     = EMIT;
                  dcnt_d      = '0;
                  pressed_d   = 1'b1;
                  key_valid_d = (emit_code != 4'hF);
                  key_d       = emit_code;
               end else if (dcnt_q < DW'(DEBOUNCE_TICKS)) begin
                  dcnt_d = dcnt_q + DW'(1);
               end
            end else begin
               state_d = SCAN;
               dcnt_d  = '0;
               slot_d  = '0;
               ridx_d  = ridx_q + 2'd1;
            end
         end
         EMIT: begin
            state_d = RELEASE;
            dcnt_d  = '0;
         end
         default: begin
            if (cs_q == 4'hF) begin
               if (dcnt_q == DW'(DEBOUNCE_TICKS - 1)) begin
                  state_d   = SCAN;
                  pressed_d = 1'b0;
                  dcnt_d    = '0;
                  slot_d    = '0;
                  ridx_d    = ridx_q + 2'd1;
               end else if (dcnt_q < DW'(DEBOUNCE_TICKS)) begin
                  dcnt_d = dcnt_q + DW'(1);
               end
            end else begin
               dcnt_d = '0;
            end
         end
      endcase

      row_d = ~(4'b0001 << ridx_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SCAN;
         cs1_q       <= 4'hF;
         cs_q        <= 4'hF;
         slot_q      <= '0;
         ridx_q      <= 2'd0;
         cidx_q      <= 2'd0;
         lcol_q      <= 4'hF;
         dcnt_q      <= '0;
         row_q       <= 4'b1110;
         key_q       <= 4'hF;
         key_valid_q <= 1'b0;
         pressed_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cs1_q       <= cs1_d;
         cs_q        <= cs_d;
         slot_q      <= slot_d;
         ridx_q      <= ridx_d;
         cidx_q      <= cidx_d;
         lcol_q      <= lcol_d;
         dcnt_q      <= dcnt_d;
         row_q       <= row_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         pressed_q   <= pressed_d;
      end
   end

   assign bus.row       = row_q;
   assign bus.key       = key_q;
   assign bus.key_valid = key_valid_q;
   assign bus.pressed   = pressed_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Keypad scanner bench: behavioural keypad drives col from row; expected codes are queued
// at press time and a free-running monitor pops them whenever key_valid is seen.
module tb_key_matrix_scan;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   key_matrix_scan_if bus();

   key_matrix_scan #(.ROW_TICKS(4), .DEBOUNCE_TICKS(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] keys_down;   // bit r*4+c = key at row r, column c held
   logic        bounce_up;   // contact bounce: held keys momentarily open
   logic [3:0]  exp_q[$];
   int          checks = 0;
   int          passes = 0;

   // Passive keypad: a held key pulls its column low while its row is driven low.
   always_comb begin
      bus.col = 4'hF;
      if (!bounce_up) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               if (keys_down[r*4+c] && !bus.row[r]) bus.col[c] = 1'b0;
      end
   end

   // Code from the printed keypad legend.
   function automatic logic [3:0] key_code(input int r, input int c);
      string legend = "123A456B789C*0#D";
      byte   ch;
      ch = legend[r*4+c];
      if (ch >= 8'd48 && ch <= 8'd57) return 4'(ch - 8'd48);
      if (ch >= 8'd65 && ch <= 8'd68) return 4'(ch - 8'd55);
      if (ch == 8'd42) return 4'hE;
      return 4'hF;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tap(input int r, input int c, input int hold, input bit expect_emit);
      logic [3:0] code;
      code = key_code(r, c);
      if (expect_emit && code != 4'hF) exp_q.push_back(code);
      $display("press key r%0d c%0d code %0h hold %0d", r, c, code, hold);
      keys_down[r*4+c] = 1'b1;
      tick(hold);
      keys_down = '0;
      tick(40);
   endtask

   // Monitor: every cycle the bus is either idle or carries the next queued code.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.key_valid) begin
            $display("emit key %0h", bus.key);
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_key: got key %0h with key_valid, required none", bus.key);
            end else begin
               check("key_code", int'(bus.key), int'(exp_q.pop_front()));
            end
         end else begin
            check("idle_key", int'(bus.key), 15);
         end
      end
   end

   initial begin
      logic [3:0] er;
      logic [3:0] seen;
      bit         found;

      rst       = 1'b1;
      keys_down = '0;
      bounce_up = 1'b0;
      tick(3);
      check("reset_row", int'(bus.row), 14);
      check("reset_key", int'(bus.key), 15);
      check("reset_valid", int'(bus.key_valid), 0);
      check("reset_pressed", int'(bus.pressed), 0);
      rst = 1'b0;

      // Idle scan rotation, 4 cycles per row.
      for (int i = 0; i < 32; i++) begin
         er = ~(4'b0001 << ((i / 4) % 4));
         check("scan_row", int'(bus.row), int'(er));
         tick(1);
      end

      // Clean '5' press, pressed held until release is debounced.
      exp_q.push_back(key_code(1, 1));
      keys_down[5] = 1'b1;
      tick(60);
      check("pressed_hold", int'(bus.pressed), 1);
      keys_down = '0;
      tick(15);
      check("pressed_release_early", int'(bus.pressed), 1);
      tick(15);
      check("pressed_released", int'(bus.pressed), 0);
      tick(10);

      // Bouncing '7' then settled.
      exp_q.push_back(key_code(2, 0));
      keys_down[8] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         bounce_up = ((i / 3) % 2) == 1;
         tick(1);
      end
      bounce_up = 1'b0;
      tick(55);
      keys_down = '0;
      tick(40);

      // Press shorter than the debounce window.
      tap(2, 1, int'($urandom_range(4, 10)), 1'b0);
      check("short_pressed", int'(bus.pressed), 0);

      // Chord on the top row: ignored, scanning continues.
      keys_down[0] = 1'b1;
      keys_down[1] = 1'b1;
      seen = 4'h0;
      for (int i = 0; i < 40; i++) begin
         seen |= ~bus.row;
         tick(1);
      end
      check("chord_scan", int'(seen), 15);
      check("chord_pressed", int'(bus.pressed), 0);
      keys_down = '0;
      tick(10);

      // '#' runs the press sequence without emitting.
      keys_down[14] = 1'b1;
      tick(60);
      check("hash_pressed", int'(bus.pressed), 1);
      keys_down = '0;
      tick(40);
      check("hash_released", int'(bus.pressed), 0);
      tap(1, 3, 60, 1'b1);
      tap(3, 0, 60, 1'b1);

      // Random presses: long ones emit, short ones must not.
      for (int n = 0; n < 10; n++) begin
         int r, c;
         r = int'($urandom_range(0, 3));
         c = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) tap(r, c, int'($urandom_range(3, 12)), 1'b0);
         else                           tap(r, c, int'($urandom_range(50, 80)), 1'b1);
      end

      // Reset during debounce of '3'; still-held key emits once afterwards.
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.row == 4'b1101) found = 1'b1;
         else tick(1);
      end
      check("wait_row1", int'(found), 1);
      exp_q.push_back(key_code(0, 2));
      keys_down[2] = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bus.row == 4'b1110) found = 1'b1;
         else tick(1);
      end
      check("wait_row0", int'(found), 1);
      tick(8);
      #1 rst = 1'b1;
      #1;
      check("async_row", int'(bus.row), 14);
      check("async_key", int'(bus.key), 15);
      check("async_valid", int'(bus.key_valid), 0);
      check("async_pressed", int'(bus.pressed), 0);
      tick(1);
      rst = 1'b0;
      tick(60);
      keys_down = '0;
      tick(40);

      check("pending_emissions", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
